// File: rtl/led_pattern_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_pattern_gen_pkg                                    |
// | Description : Shared encodings and colour-scaling helpers for the    |
// |               LED pattern generator.                                 |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package led_pattern_gen_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_RAINBOW = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int G_HI     = 23;
    localparam int R_HI     = 15;
    localparam int B_HI     = 7;
    localparam int LED_BITS = 24;

    // (c * (s + 1)) >> 8 so that s = 255 passes the component through unchanged
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] s);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, s} + 16'd1);
        return p[15:8];
    endfunction

    function automatic logic [23:0] scale_grb(input logic [23:0] grb, input logic [7:0] s);
        return {scale8(grb[G_HI -: 8], s),
                scale8(grb[R_HI -: 8], s),
                scale8(grb[B_HI -: 8], s)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_color_wheel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_color_wheel                                        |
// | Description : Combinational 8-bit hue to GRB colour wheel.           |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module led_color_wheel (
    input  logic [7:0]  hue_i,
    output logic [23:0] grb_o
);

    logic [7:0] w_h3;

    always_comb begin
        w_h3  = 8'd0;
        grb_o = 24'd0;
        if (hue_i < 8'd85) begin
            w_h3  = hue_i * 8'd3;
            grb_o = {w_h3, 8'd255 - w_h3, 8'd0};
        end else if (hue_i < 8'd170) begin
            w_h3  = (hue_i - 8'd85) * 8'd3;
            grb_o = {8'd255 - w_h3, 8'd0, w_h3};
        end else begin
            w_h3  = (hue_i - 8'd170) * 8'd3;
            grb_o = {8'd0, w_h3, 8'd255 - w_h3};
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_pattern_gen                                        |
// | Description : Frame-based LED animation generator producing a packed |
// |               GRB vector, committed atomically once per frame.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int LED_CNT      = 1,
    parameter int FRAME_DIV    = 500000,
    parameter int HUE_STEP     = 2,
    parameter int HUE_SPREAD   = 16,
    parameter int BREATHE_STEP = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic [1:0]                    mode_i,
    input  logic [23:0]                   color_i,
    input  logic [7:0]                    brightness_i,
    output logic [LED_BITS*LED_CNT-1:0]   data_o,
    output logic                          frame_o,
    output logic                          busy_o
);

    localparam int IDX_W  = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int DATA_W = LED_BITS * LED_CNT;

    state_t               state_q;
    logic [CNT_W-1:0]     div_q;
    logic                 w_tick;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     pos_q, pos_d;
    logic [7:0]           hue_q, hue_d;
    logic [7:0]           level_q, level_d;
    logic                 dir_down_q, dir_down_d;
    logic [8:0]           w_level_sum;
    logic [1:0]           mode_q;
    logic [23:0]          color_q;
    logic [7:0]           bright_q;
    logic [DATA_W-1:0]    shadow_q;
    logic [DATA_W-1:0]    data_q, frame_d;
    logic                 frame_q, busy_q;
    logic [7:0]           w_wheel_hue;
    logic [23:0]          w_wheel_grb, w_led_grb;

    assign data_o  = data_q;
    assign frame_o = frame_q;
    assign busy_o  = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else if (enable_i) begin
            div_q <= (div_q == CNT_W'(FRAME_DIV - 1)) ? '0 : div_q + CNT_W'(1);
        end
    end

    assign w_tick = enable_i && (div_q == CNT_W'(FRAME_DIV - 1));

    assign w_wheel_hue = hue_q + 8'(32'(idx_q) * HUE_SPREAD);

    led_color_wheel u_wheel (
        .hue_i (w_wheel_hue),
        .grb_o (w_wheel_grb)
    );

    always_comb begin
        w_led_grb = 24'd0;
        case (mode_q)
            MODE_STATIC:  w_led_grb = scale_grb(color_q, bright_q);
            MODE_RAINBOW: w_led_grb = scale_grb(w_wheel_grb, bright_q);
            MODE_CHASE:   w_led_grb = (idx_q == pos_q) ? scale_grb(color_q, bright_q) : 24'd0;
            default:      w_led_grb = scale_grb(color_q, level_q);
        endcase
    end

    // Animation state for the next frame; only latched at COMMIT
    always_comb begin
        hue_d       = hue_q + 8'(HUE_STEP);
        pos_d       = (pos_q == IDX_W'(LED_CNT - 1)) ? '0 : pos_q + IDX_W'(1);
        level_d     = level_q;
        dir_down_d  = dir_down_q;
        w_level_sum = {1'b0, level_q} + 9'(BREATHE_STEP);
        if (!dir_down_q) begin
            if (w_level_sum >= 9'd255) begin
                level_d    = 8'd255;
                dir_down_d = 1'b1;
            end else begin
                level_d = w_level_sum[7:0];
            end
        end else begin
            if ({1'b0, level_q} <= 9'(BREATHE_STEP)) begin
                level_d    = 8'd0;
                dir_down_d = 1'b0;
            end else begin
                level_d = level_q - 8'(BREATHE_STEP);
            end
        end
    end

    // The LED computed in the final CALC cycle bypasses the shadow into the frame
    for (genvar k = 0; k < LED_CNT; k++) begin : g_pack
        assign frame_d[LED_BITS*k +: LED_BITS] =
            (idx_q == IDX_W'(k)) ? w_led_grb : shadow_q[LED_BITS*k +: LED_BITS];
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_CALC) begin
            for (int k = 0; k < LED_CNT; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    shadow_q[LED_BITS*k +: LED_BITS] <= w_led_grb;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            pos_q      <= '0;
            hue_q      <= 8'd0;
            level_q    <= 8'd0;
            dir_down_q <= 1'b0;
            mode_q     <= MODE_STATIC;
            color_q    <= 24'd0;
            bright_q   <= 8'd0;
            data_q     <= '0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_tick) begin
                        mode_q   <= mode_i;
                        color_q  <= color_i;
                        bright_q <= brightness_i;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (idx_q == IDX_W'(LED_CNT - 1)) begin
                        data_q  <= frame_d;
                        frame_q <= 1'b1;
                        state_q <= ST_COMMIT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_COMMIT: begin
                    hue_q      <= hue_d;
                    pos_q      <= pos_d;
                    level_q    <= level_d;
                    dir_down_q <= dir_down_d;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
